// File: rtl/npc_pkg.sv
// rtl/npc_pkg.sv - shared state encodings and owner constants for the memory arbiter
package npc_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_REQ  = 2'd1,
    ARB_RSP  = 2'd2
  } arb_state_e;

  localparam logic OWNER_IFU = 1'b0;
  localparam logic OWNER_LSU = 1'b1;

endpackage

// File: rtl/mem_arb_pick.sv
// rtl/mem_arb_pick.sv - IFU/LSU tie-break; MEM_ARB_RR_EN selects round-robin, else LSU priority
module mem_arb_pick
  import npc_pkg::*;
(
  input  logic ifu_valid,
  input  logic lsu_valid,
  input  logic last_owner,
  output logic grant_ifu,
  output logic grant_lsu
);

  logic lsu_wins_tie;

`ifdef MEM_ARB_RR_EN
  // The LSU takes a tie only when the IFU was the previous owner
  assign lsu_wins_tie = (last_owner == OWNER_IFU);
`else
  // Fixed priority ignores history entirely
  logic unused_last_owner;
  assign unused_last_owner = last_owner;
  assign lsu_wins_tie      = 1'b1;
`endif

  assign grant_lsu = lsu_valid & (~ifu_valid | lsu_wins_tie);
  assign grant_ifu = ifu_valid & ~grant_lsu;

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - single-outstanding IFU/LSU memory port arbiter; MEM_ARB_RR_EN enables round-robin ties
module mem_arbiter
  import npc_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ifu_req_valid,
  output logic                ifu_req_ready,
  input  logic [ADDR_W-1:0]   ifu_addr,
  output logic                ifu_rsp_valid,
  input  logic                ifu_rsp_ready,
  output logic [DATA_W-1:0]   ifu_rdata,
  input  logic                lsu_req_valid,
  output logic                lsu_req_ready,
  input  logic [ADDR_W-1:0]   lsu_addr,
  input  logic                lsu_wen,
  input  logic [DATA_W-1:0]   lsu_wdata,
  input  logic [DATA_W/8-1:0] lsu_wmask,
  output logic                lsu_rsp_valid,
  input  logic                lsu_rsp_ready,
  output logic [DATA_W-1:0]   lsu_rdata,
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic                mem_wen,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wmask,
  input  logic                mem_rsp_valid,
  output logic                mem_rsp_ready,
  input  logic [DATA_W-1:0]   mem_rdata
);

  localparam int MASK_W = DATA_W / 8;

  arb_state_e          state;
  logic                owner;
  logic [ADDR_W-1:0]   addr_q;
  logic                wen_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [MASK_W-1:0]   wmask_q;

  logic last_owner;
  logic grant_ifu;
  logic grant_lsu;
  logic in_idle;
  logic in_req;
  logic in_rsp;
  logic ifu_accept;
  logic lsu_accept;
  logic owner_rsp_ready;

  mem_arb_pick u_pick (
    .ifu_valid  (ifu_req_valid),
    .lsu_valid  (lsu_req_valid),
    .last_owner (last_owner),
    .grant_ifu  (grant_ifu),
    .grant_lsu  (grant_lsu)
  );

  assign in_idle = (state == ARB_IDLE);
  assign in_req  = (state == ARB_REQ);
  assign in_rsp  = (state == ARB_RSP);

  // Ready depends only on state and the requester valids, never on the memory side
  assign ifu_req_ready = in_idle & grant_ifu;
  assign lsu_req_ready = in_idle & grant_lsu;
  assign ifu_accept    = ifu_req_valid & ifu_req_ready;
  assign lsu_accept    = lsu_req_valid & lsu_req_ready;

  assign mem_req_valid = in_req;
  assign mem_addr      = addr_q;
  assign mem_wen       = wen_q;
  assign mem_wdata     = wdata_q;
  assign mem_wmask     = wmask_q;

  // Response is a straight pass-through to whoever owns the transaction
  assign owner_rsp_ready = (owner == OWNER_LSU) ? lsu_rsp_ready : ifu_rsp_ready;
  assign mem_rsp_ready   = in_rsp & owner_rsp_ready;
  assign ifu_rsp_valid   = in_rsp & (owner == OWNER_IFU) & mem_rsp_valid;
  assign lsu_rsp_valid   = in_rsp & (owner == OWNER_LSU) & mem_rsp_valid;
  assign ifu_rdata       = ifu_rsp_valid ? mem_rdata : '0;
  assign lsu_rdata       = lsu_rsp_valid ? mem_rdata : '0;

`ifdef MEM_ARB_RR_EN
  // Remember who was served last so the next tie goes the other way
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_owner <= OWNER_LSU;
    end else if (lsu_accept) begin
      last_owner <= OWNER_LSU;
    end else if (ifu_accept) begin
      last_owner <= OWNER_IFU;
    end
  end
`else
  assign last_owner = OWNER_LSU;
`endif

  // Walk IDLE -> REQ -> RSP, capturing the winner's payload at acceptance
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ARB_IDLE;
      owner   <= OWNER_IFU;
      addr_q  <= '0;
      wen_q   <= 1'b0;
      wdata_q <= '0;
      wmask_q <= '0;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (lsu_accept) begin
            owner   <= OWNER_LSU;
            addr_q  <= lsu_addr;
            wen_q   <= lsu_wen;
            wdata_q <= lsu_wdata;
            wmask_q <= lsu_wmask;
            state   <= ARB_REQ;
          end else if (ifu_accept) begin
            owner   <= OWNER_IFU;
            addr_q  <= ifu_addr;
            wen_q   <= 1'b0;
            wdata_q <= '0;
            wmask_q <= '0;
            state   <= ARB_REQ;
          end
        end
        ARB_REQ: begin
          if (mem_req_ready) begin
            state <= ARB_RSP;
          end
        end
        ARB_RSP: begin
          if (mem_rsp_valid && owner_rsp_ready) begin
            state <= ARB_IDLE;
          end
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ifu_req_valid = 1'b0;
  logic        ifu_req_ready;
  logic [31:0] ifu_addr = '0;
  logic        ifu_rsp_valid;
  logic        ifu_rsp_ready = 1'b0;
  logic [31:0] ifu_rdata;
  logic        lsu_req_valid = 1'b0;
  logic        lsu_req_ready;
  logic [31:0] lsu_addr = '0;
  logic        lsu_wen = 1'b0;
  logic [31:0] lsu_wdata = '0;
  logic [3:0]  lsu_wmask = '0;
  logic        lsu_rsp_valid;
  logic        lsu_rsp_ready = 1'b0;
  logic [31:0] lsu_rdata;
  logic        mem_req_valid;
  logic        mem_req_ready = 1'b0;
  logic [31:0] mem_addr;
  logic        mem_wen;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;
  logic        mem_rsp_valid = 1'b0;
  logic        mem_rsp_ready;
  logic [31:0] mem_rdata = '0;

  int n_cmp = 0;
  int n_err = 0;

`ifdef MEM_ARB_RR_EN
  localparam bit RR_EN = 1'b1;
`else
  localparam bit RR_EN = 1'b0;
`endif

  // Round-robin history kept by the bench: 0 = IFU, 1 = LSU
  bit rr_last = 1'b1;

  always #5 clk = ~clk;

  mem_arbiter dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .ifu_req_valid (ifu_req_valid),
    .ifu_req_ready (ifu_req_ready),
    .ifu_addr      (ifu_addr),
    .ifu_rsp_valid (ifu_rsp_valid),
    .ifu_rsp_ready (ifu_rsp_ready),
    .ifu_rdata     (ifu_rdata),
    .lsu_req_valid (lsu_req_valid),
    .lsu_req_ready (lsu_req_ready),
    .lsu_addr      (lsu_addr),
    .lsu_wen       (lsu_wen),
    .lsu_wdata     (lsu_wdata),
    .lsu_wmask     (lsu_wmask),
    .lsu_rsp_valid (lsu_rsp_valid),
    .lsu_rsp_ready (lsu_rsp_ready),
    .lsu_rdata     (lsu_rdata),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_addr      (mem_addr),
    .mem_wen       (mem_wen),
    .mem_wdata     (mem_wdata),
    .mem_wmask     (mem_wmask),
    .mem_rsp_valid (mem_rsp_valid),
    .mem_rsp_ready (mem_rsp_ready),
    .mem_rdata     (mem_rdata)
  );

  // {ifu_req_ready, lsu_req_ready, mem_req_valid, mem_rsp_ready, ifu_rsp_valid, lsu_rsp_valid}
  function automatic logic [5:0] ctl();
    return {ifu_req_ready, lsu_req_ready, mem_req_valid, mem_rsp_ready, ifu_rsp_valid, lsu_rsp_valid};
  endfunction

  function automatic logic [68:0] payload();
    return {mem_addr, mem_wen, mem_wdata, mem_wmask};
  endfunction

  // Winner per arbitration rules: -1 none, 0 IFU, 1 LSU
  function automatic int pick(bit iv, bit lv);
    if (iv && lv) return RR_EN ? (rr_last ? 0 : 1) : 1;
    if (lv) return 1;
    if (iv) return 0;
    return -1;
  endfunction

  task automatic clear_inputs();
    ifu_req_valid = 1'b0; ifu_addr = '0; ifu_rsp_ready = 1'b0;
    lsu_req_valid = 1'b0; lsu_addr = '0; lsu_wen = 1'b0; lsu_wdata = '0; lsu_wmask = '0;
    lsu_rsp_ready = 1'b0; mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rdata = '0;
  endtask

  task automatic drain();
    @(negedge clk);
    ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;
    mem_req_ready = 1'b1; mem_rsp_valid = 1'b1; ifu_rsp_ready = 1'b1; lsu_rsp_ready = 1'b1;
    repeat (2) @(negedge clk);
    clear_inputs();
  endtask

  task automatic do_reset();
    @(negedge clk);
    clear_inputs();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    rr_last = 1'b1;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    mem_rsp_valid = 1'b1;
    mem_rdata = $urandom;
    #1;
    n_cmp++;
    if ({ctl(), mem_wen} !== 7'b0) begin
      n_err++; $display("FAIL reset_ctl: got %b want 0000000", {ctl(), mem_wen});
    end
    n_cmp++;
    if ({mem_addr, mem_wdata, mem_wmask, ifu_rdata, lsu_rdata} !== 132'd0) begin
      n_err++; $display("FAIL reset_data: got %h want 0", {mem_addr, mem_wdata, mem_wmask, ifu_rdata, lsu_rdata});
    end
    clear_inputs();
    rst_n = 1'b1;
    rr_last = 1'b1;
  endtask

  task automatic test_ifu_read();
    @(negedge clk);
    ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0000; mem_req_ready = 1'b1; ifu_rsp_ready = 1'b1;
    #1;
    n_cmp++;
    if (ctl() !== 6'b100000) begin n_err++; $display("FAIL ifu_accept: got %b want 100000", ctl()); end
    @(negedge clk);
    ifu_req_valid = 1'b0;
    #1;
    n_cmp++;
    if (ctl() !== 6'b001000) begin n_err++; $display("FAIL ifu_req_ctl: got %b want 001000", ctl()); end
    n_cmp++;
    if (payload() !== {32'h8000_0000, 1'b0, 32'h0, 4'h0}) begin
      n_err++; $display("FAIL ifu_req_payload: got %h want %h", payload(), {32'h8000_0000, 1'b0, 32'h0, 4'h0});
    end
    @(negedge clk);
    mem_rsp_valid = 1'b1; mem_rdata = 32'h0000_0413;
    #1;
    n_cmp++;
    if (ctl() !== 6'b000110) begin n_err++; $display("FAIL ifu_rsp_ctl: got %b want 000110", ctl()); end
    n_cmp++;
    if ({ifu_rdata, lsu_rdata} !== {32'h0000_0413, 32'h0}) begin
      n_err++; $display("FAIL ifu_rsp_data: got %h %h want 00000413 00000000", ifu_rdata, lsu_rdata);
    end
    @(negedge clk);
    mem_rsp_valid = 1'b0; ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0004;
    #1;
    n_cmp++;
    if (ctl() !== 6'b100000) begin n_err++; $display("FAIL ifu_back_idle: got %b want 100000", ctl()); end
    ifu_req_valid = 1'b0;
    rr_last = 1'b0;
    clear_inputs();
  endtask

  task automatic test_lsu_priority();
    logic [31:0] rd;
    @(negedge clk);
    ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0004;
    lsu_req_valid = 1'b1; lsu_addr = 32'h8000_0100; lsu_wen = 1'b1;
    lsu_wdata = 32'hDEAD_BEEF; lsu_wmask = 4'b0011; mem_req_ready = 1'b0;
    #1;
    n_cmp++;
    if (ctl() !== 6'b010000) begin n_err++; $display("FAIL prio_grant: got %b want 010000", ctl()); end
    @(negedge clk);
    lsu_req_valid = 1'b0; lsu_wen = 1'b0; lsu_wdata = '0; lsu_wmask = '0; mem_req_ready = 1'b1;
    #1;
    n_cmp++;
    if (ctl() !== 6'b001000) begin n_err++; $display("FAIL prio_req_ctl: got %b want 001000", ctl()); end
    n_cmp++;
    if (payload() !== {32'h8000_0100, 1'b1, 32'hDEAD_BEEF, 4'b0011}) begin
      n_err++; $display("FAIL prio_req_payload: got %h want %h", payload(), {32'h8000_0100, 1'b1, 32'hDEAD_BEEF, 4'b0011});
    end
    @(negedge clk);
    rd = $urandom;
    mem_rsp_valid = 1'b1; mem_rdata = rd; lsu_rsp_ready = 1'b1;
    #1;
    n_cmp++;
    if (ctl() !== 6'b000101) begin n_err++; $display("FAIL prio_rsp_ctl: got %b want 000101", ctl()); end
    n_cmp++;
    if ({ifu_rdata, lsu_rdata} !== {32'h0, rd}) begin
      n_err++; $display("FAIL prio_rsp_data: got %h %h want 00000000 %h", ifu_rdata, lsu_rdata, rd);
    end
    @(negedge clk);
    mem_rsp_valid = 1'b0;
    #1;
    n_cmp++;
    if (ctl() !== 6'b100000) begin n_err++; $display("FAIL prio_ifu_next: got %b want 100000", ctl()); end
    @(negedge clk);
    ifu_req_valid = 1'b0;
    #1;
    n_cmp++;
    if (payload() !== {32'h8000_0004, 1'b0, 32'h0, 4'h0}) begin
      n_err++; $display("FAIL prio_ifu_payload: got %h want %h", payload(), {32'h8000_0004, 1'b0, 32'h0, 4'h0});
    end
    rr_last = 1'b0;
    drain();
  endtask

  task automatic test_stall_backpressure();
    logic [68:0] exp_pl;
    logic [31:0] a, wd, rd;
    logic [3:0]  wm;
    a  = 32'h8000_0000 | (32'($urandom_range(0, 255)) << 2);
    wd = $urandom;
    wm = 4'($urandom);
    exp_pl = {a, 1'b1, wd, wm};
    @(negedge clk);
    lsu_req_valid = 1'b1; lsu_addr = a; lsu_wen = 1'b1; lsu_wdata = wd; lsu_wmask = wm; mem_req_ready = 1'b0;
    #1;
    n_cmp++;
    if (ctl() !== 6'b010000) begin n_err++; $display("FAIL stall_accept: got %b want 010000", ctl()); end
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      lsu_req_valid = 1'b0; lsu_addr = $urandom; lsu_wdata = $urandom; lsu_wmask = 4'($urandom);
      ifu_req_valid = 1'b1; ifu_addr = $urandom;
      mem_req_ready = 1'b0; mem_rsp_valid = 1'($urandom_range(0, 1)); mem_rdata = $urandom;
      #1;
      n_cmp++;
      if (ctl() !== 6'b001000) begin n_err++; $display("FAIL stall_ctl[%0d]: got %b want 001000", k, ctl()); end
      n_cmp++;
      if (payload() !== exp_pl) begin n_err++; $display("FAIL stall_payload[%0d]: got %h want %h", k, payload(), exp_pl); end
    end
    @(negedge clk);
    ifu_req_valid = 1'b0; mem_req_ready = 1'b1; mem_rsp_valid = 1'b0;
    #1;
    n_cmp++;
    if (ctl() !== 6'b001000) begin n_err++; $display("FAIL stall_release: got %b want 001000", ctl()); end
    rd = $urandom;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      mem_req_ready = 1'b0; mem_rsp_valid = 1'b1; mem_rdata = rd; lsu_rsp_ready = 1'b0;
      #1;
      n_cmp++;
      if (ctl() !== 6'b000001) begin n_err++; $display("FAIL bp_ctl[%0d]: got %b want 000001", k, ctl()); end
      n_cmp++;
      if (lsu_rdata !== rd) begin n_err++; $display("FAIL bp_data[%0d]: got %h want %h", k, lsu_rdata, rd); end
    end
    @(negedge clk);
    lsu_rsp_ready = 1'b1;
    #1;
    n_cmp++;
    if (ctl() !== 6'b000101) begin n_err++; $display("FAIL bp_release: got %b want 000101", ctl()); end
    @(negedge clk);
    #1;
    n_cmp++;
    if ({ctl(), ifu_rdata, lsu_rdata} !== 70'd0) begin
      n_err++; $display("FAIL idle_rsp_ignored: got %b %h %h want 000000 0 0", ctl(), ifu_rdata, lsu_rdata);
    end
    rr_last = 1'b1;
    clear_inputs();
  endtask

  task automatic test_tie_policy();
    int win;
    logic [31:0] ia, la, exp_a;
    do_reset();
    ia = 32'h0000_1000; la = 32'h0000_2000;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      ifu_req_valid = 1'b1; ifu_addr = ia; lsu_req_valid = 1'b1; lsu_addr = la; lsu_wen = 1'b0;
      mem_req_ready = 1'b1; mem_rsp_valid = 1'b1; mem_rdata = $urandom;
      ifu_rsp_ready = 1'b1; lsu_rsp_ready = 1'b1;
      #1;
      win = pick(1'b1, 1'b1);
      n_cmp++;
      if (ctl() !== ((win == 1) ? 6'b010000 : 6'b100000)) begin
        n_err++; $display("FAIL tie_grant[%0d]: got %b want winner %0d", k, ctl(), win);
      end
      exp_a = (win == 1) ? la : ia;
      rr_last = (win == 1);
      @(negedge clk);
      if (win == 1) la = la + 32'd4; else ia = ia + 32'd4;
      ifu_addr = ia; lsu_addr = la;
      #1;
      n_cmp++;
      if (mem_addr !== exp_a) begin n_err++; $display("FAIL tie_addr[%0d]: got %h want %h", k, mem_addr, exp_a); end
      @(negedge clk);
      #1;
      n_cmp++;
      if (ctl() !== ((win == 1) ? 6'b000101 : 6'b000110)) begin
        n_err++; $display("FAIL tie_rsp[%0d]: got %b want owner %0d", k, ctl(), win);
      end
    end
    drain();
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0040; mem_req_ready = 1'b1; ifu_rsp_ready = 1'b0;
    @(negedge clk);
    ifu_req_valid = 1'b0;
    @(negedge clk);
    mem_rsp_valid = 1'b1; mem_rdata = $urandom;
    #1;
    n_cmp++;
    if (ctl() !== 6'b000010) begin n_err++; $display("FAIL arst_pre: got %b want 000010", ctl()); end
    #1;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({ctl(), ifu_rdata, payload()} !== 107'd0) begin
      n_err++; $display("FAIL arst_outputs: got %b %h %h want all 0", ctl(), ifu_rdata, payload());
    end
    @(negedge clk);
    rst_n = 1'b1;
    rr_last = 1'b1;
    clear_inputs();
    ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0080; mem_req_ready = 1'b1;
    #1;
    n_cmp++;
    if (ctl() !== 6'b100000) begin n_err++; $display("FAIL arst_first_accept: got %b want 100000", ctl()); end
    @(negedge clk);
    ifu_req_valid = 1'b0;
    #1;
    n_cmp++;
    if ({mem_req_valid, mem_addr} !== {1'b1, 32'h8000_0080}) begin
      n_err++; $display("FAIL arst_req: got %b %h want 1 80000080", mem_req_valid, mem_addr);
    end
    rr_last = 1'b0;
    drain();
  endtask

  task automatic test_random();
    logic [31:0] mem [16];
    bit          ip, lp, busy, ph, own, rp, own_rdy;
    logic [31:0] ia, la, lwd, ta, twd, rd;
    logic        lw, tw;
    logic [3:0]  lwm, twm, idx;
    logic [5:0]  exp_ctl;
    int          win;
    ip = 0; lp = 0; busy = 0; ph = 0; own = 0; rp = 0; rd = '0;
    ia = '0; la = '0; lwd = '0; lw = 0; lwm = '0; ta = '0; twd = '0; tw = 0; twm = '0;
    for (int i = 0; i < 16; i++) mem[i] = $urandom;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (!ip && $urandom_range(0, 2) == 0) begin
        ip = 1; ia = 32'h8000_0000 | (32'($urandom_range(0, 15)) << 2);
      end
      if (!lp && $urandom_range(0, 2) == 0) begin
        lp = 1; la = 32'h8000_0000 | (32'($urandom_range(0, 15)) << 2);
        lw = 1'($urandom_range(0, 1)); lwd = $urandom; lwm = 4'($urandom);
      end
      ifu_req_valid = ip; ifu_addr = ip ? ia : $urandom;
      lsu_req_valid = lp; lsu_addr = lp ? la : $urandom;
      lsu_wen = lp ? lw : 1'($urandom_range(0, 1));
      lsu_wdata = lp ? lwd : $urandom; lsu_wmask = lp ? lwm : 4'($urandom);
      mem_req_ready = 1'($urandom_range(0, 1));
      ifu_rsp_ready = 1'($urandom_range(0, 1));
      lsu_rsp_ready = 1'($urandom_range(0, 1));
      mem_rsp_valid = 1'($urandom_range(0, 1));
      mem_rdata = rp ? rd : $urandom;
      #1;
      win = busy ? -1 : pick(ip, lp);
      own_rdy = own ? lsu_rsp_ready : ifu_rsp_ready;
      exp_ctl = {win == 0, win == 1, busy & !ph, busy & ph & own_rdy,
                 busy & ph & !own & mem_rsp_valid, busy & ph & own & mem_rsp_valid};
      n_cmp++;
      if (ctl() !== exp_ctl) begin n_err++; $display("FAIL rnd_ctl[%0d]: got %b want %b", c, ctl(), exp_ctl); end
      if (busy && !ph) begin
        n_cmp++;
        if (payload() !== {ta, tw, twd, twm}) begin
          n_err++; $display("FAIL rnd_payload[%0d]: got %h want %h", c, payload(), {ta, tw, twd, twm});
        end
      end
      n_cmp++;
      if ({ifu_rdata, lsu_rdata} !== {exp_ctl[1] ? rd : 32'h0, exp_ctl[0] ? rd : 32'h0}) begin
        n_err++; $display("FAIL rnd_rdata[%0d]: got %h %h want %h %h", c, ifu_rdata, lsu_rdata,
                          exp_ctl[1] ? rd : 32'h0, exp_ctl[0] ? rd : 32'h0);
      end
      if (win == 0) begin
        busy = 1; ph = 0; own = 0; ta = ia; tw = 0; twd = '0; twm = '0; ip = 0; rr_last = 1'b0;
      end else if (win == 1) begin
        busy = 1; ph = 0; own = 1; ta = la; tw = lw; twd = lwd; twm = lwm; lp = 0; rr_last = 1'b1;
      end else if (busy && !ph && mem_req_ready) begin
        ph = 1; rp = 1; idx = ta[5:2];
        if (tw) begin
          rd = '0;
          for (int b = 0; b < 4; b++) if (twm[b]) mem[idx][8*b +: 8] = twd[8*b +: 8];
        end else begin
          rd = mem[idx];
        end
      end else if (busy && ph && mem_rsp_valid && own_rdy) begin
        busy = 0; ph = 0; rp = 0;
      end
    end
    drain();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_ifu_read();
    test_lsu_priority();
    test_stall_backpressure();
    test_tie_policy();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares the single NPC memory port between the instruction-fetch requester (IFU) and the load/store requester (LSU). One transaction is outstanding at a time. A three-state FSM latches the winning request, presents it to memory with a valid/ready handshake, and routes the response back to the requester that owns the transaction. It sits between IFU/LSU and the memory model, below the decoder-driven `mem_ren`/`mem_wen` control path.

## Interface
- `ADDR_W`, 32: address width
- `DATA_W`, 32: data width; `DATA_W/8` mask bits
- `clk` in 1: single clock
- `rst_n` in 1: reset, asynchronous, active-low
- `ifu_req_valid` in 1 / `ifu_req_ready` out 1 / `ifu_addr` in ADDR_W: IFU read request
- `ifu_rsp_valid` out 1 / `ifu_rsp_ready` in 1 / `ifu_rdata` out DATA_W: IFU response
- `lsu_req_valid` in 1 / `lsu_req_ready` out 1 / `lsu_addr` in ADDR_W: LSU request
- `lsu_wen` in 1 / `lsu_wdata` in DATA_W / `lsu_wmask` in DATA_W/8: LSU write controls
- `lsu_rsp_valid` out 1 / `lsu_rsp_ready` in 1 / `lsu_rdata` out DATA_W: LSU response (also acks writes)
- `mem_req_valid` out 1 / `mem_req_ready` in 1 / `mem_addr` out ADDR_W: memory request
- `mem_wen` out 1 / `mem_wdata` out DATA_W / `mem_wmask` out DATA_W/8: memory write controls
- `mem_rsp_valid` in 1 / `mem_rsp_ready` out 1 / `mem_rdata` in DATA_W: memory response

## Operation
- States: IDLE, REQ, RSP. Owner register: IFU or LSU.
- IDLE:
  - Grant is combinational. When only one requester is valid, that requester wins. When both are valid, the arbitration policy below decides.
  - The winner's `*_req_ready` is 1. The other requester's ready is 0.
  - On a handshake, latch addr, wen, wdata, wmask and the owner, then move to REQ.
  - An IFU transaction latches `wen=0`, `wdata=0` and `wmask=0`.
- REQ:
  - `mem_req_valid=1`, with `mem_*` driven from the latched registers.
  - On `mem_req_valid & mem_req_ready`, move to RSP.
  - The payload is stable while the handshake is stalled.
- RSP:
  - The owner's `*_rsp_valid = mem_rsp_valid`.
  - The owner's `*_rdata = mem_rdata`.
  - `mem_rsp_ready` = the owner's `*_rsp_ready`.
  - On the response handshake, move to IDLE.
- Outside RSP, `mem_rsp_ready=0` and both `*_rsp_valid=0`. A `mem_rsp_valid` in IDLE or REQ is ignored.
- Every `*_rdata` output is 0 whenever its `*_rsp_valid` is 0.
- All `*_req_ready` outputs are 0 in REQ and RSP.
- Requesters hold valid and payload until accepted. A request that is deasserted before acceptance is simply not served.
- Default policy: LSU wins when both requesters are valid (fixed priority).

## Timing
- Reset (asynchronous, `rst_n=0`):
  - State goes to IDLE, the owner to IFU, and the latched registers to 0. The round-robin pointer, when compiled in, resets to LSU.
  - All outputs are 0, except that `*_req_ready` may be asserted combinationally in IDLE after reset.
  - A reset mid-transaction abandons the transaction. Memory is reset together with the arbiter.
- Best case:
  - Accept at T.
  - `mem_req_valid` at T+1; if `mem_req_ready=1` then, RSP begins at T+2.
  - With `mem_rsp_valid` and the owner ready at T+2, the owner sees the response at T+2.
  - IDLE at T+3, with the next accept possible at T+3.
- No combinational path from `mem_req_ready` to any `*_req_ready`.
- The response path is combinational pass-through, with no added latency.

## Configuration
- `MEM_ARB_RR_EN` defined:
  - Round-robin policy on ties: grant the requester that does not match the `last_owner` register.
  - `last_owner` updates on every request acceptance.
  - `last_owner` resets to LSU, so the first tie goes to IFU.
- Undefined: fixed priority, LSU always wins ties, and no `last_owner` register exists.

## Structure
- Shared package `npc_pkg`:
  - State encodings `ARB_IDLE=2'd0`, `ARB_REQ=2'd1`, `ARB_RSP=2'd2`.
  - Owner constants `OWNER_IFU=1'b0`, `OWNER_LSU=1'b1`.
- Sub-module `mem_arb_pick`:
  - Combinational tie-break logic.
  - Inputs: both valids and `last_owner`.
  - Outputs: `grant_ifu` and `grant_lsu`.
  - Contains the `MEM_ARB_RR_EN` conditional.
- `mem_arbiter` holds the FSM, payload registers and response routing.

## Test plan
- IFU only, `ifu_addr=0x8000_0000`, memory ready immediately, `mem_rdata=0x0000_0413` at T+2 → `ifu_rsp_valid=1` and `ifu_rdata=0x0000_0413` at T+2; `lsu_rsp_valid` stays 0; IDLE at T+3.
- Both valid in IDLE, LSU `wen=1`, `addr=0x8000_0100`, `wdata=0xDEAD_BEEF`, `wmask=4'b0011` → LSU granted; `mem_wen=1`, `mem_wmask=4'b0011` and `mem_wdata=0xDEAD_BEEF` at T+1; `ifu_req_ready=0` until IDLE; IFU served next.
- `mem_req_ready` held 0 for 5 cycles → `mem_addr`, `mem_wdata` and `mem_wmask` are stable over all 5 cycles; no state change.
- Owner `rsp_ready=0` for 3 cycles while `mem_rsp_valid=1` → `mem_rsp_ready=0` for those cycles; the transaction completes on the cycle ready rises; `mem_rsp_valid` asserted in IDLE is ignored.
- With `MEM_ARB_RR_EN`, both valid continuously for 4 transactions → grants alternate IFU, LSU, IFU, LSU. Without the macro → LSU, LSU, LSU, LSU.
- `rst_n` pulled low during RSP → all valid/ready outputs are 0 asynchronously; after release, state is IDLE and the next IFU request is accepted in the first cycle.
